// File: rtl/soc_decerr_slv_pkg.sv
// Shared SoC constants used by the default (error) slave.
//   AXI_RESP_OKAY / AXI_RESP_DECERR : AXI response encodings.
//   ErrSlvRespData                  : R payload returned by the error slave.
//   IdWidthSlave                    : slave-side AXI ID width of the crossbar.
package soc_decerr_slv_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam logic [63:0] ErrSlvRespData = 64'hBADC_AB1E_BADC_AB1E;

    // Master-side ID width plus the bits the crossbar prepends to tell its
    // two masters apart.
    localparam int unsigned IdWidthMaster = 4;
    localparam int unsigned NrXbarMasters = 2;
    localparam int unsigned IdWidthSlave  = IdWidthMaster + $clog2(NrXbarMasters);

endpackage

// File: rtl/soc_decerr_slv.sv
// AXI4 default slave for the unmapped crossbar port.
// Completes every write with a DECERR B response and every read with a burst
// of constant DECERR beats, so a stray access never stalls the crossbar.
// Also keeps a saturating count of accepted requests and the last address.
//
// Ports:
//   clk_i, rst_ni              clock, synchronous active-low reset
//   aw_* / w_* / b_*           write address, data (discarded), response
//   ar_* / r_*                 read address and read data
//   clr_i                      synchronous clear of the miss counter
//   miss_cnt_o                 saturating count of AW + AR handshakes
//   miss_addr_o                address of the most recent accepted request
module soc_decerr_slv
    import soc_decerr_slv_pkg::*;
#(
    parameter int unsigned          IdWidth   = IdWidthSlave,
    parameter int unsigned          AddrWidth = 64,
    parameter int unsigned          DataWidth = 64,
    parameter logic [DataWidth-1:0] RespData  = ErrSlvRespData,
    parameter int unsigned          CntWidth  = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    // write address
    input  logic                 aw_valid_i,
    output logic                 aw_ready_o,
    input  logic [IdWidth-1:0]   aw_id_i,
    input  logic [AddrWidth-1:0] aw_addr_i,
    input  logic [7:0]           aw_len_i,
    // write data
    input  logic                 w_valid_i,
    output logic                 w_ready_o,
    input  logic                 w_last_i,
    // write response
    output logic                 b_valid_o,
    input  logic                 b_ready_i,
    output logic [IdWidth-1:0]   b_id_o,
    output logic [1:0]           b_resp_o,
    // read address
    input  logic                 ar_valid_i,
    output logic                 ar_ready_o,
    input  logic [IdWidth-1:0]   ar_id_i,
    input  logic [AddrWidth-1:0] ar_addr_i,
    input  logic [7:0]           ar_len_i,
    // read data
    output logic                 r_valid_o,
    input  logic                 r_ready_i,
    output logic [IdWidth-1:0]   r_id_o,
    output logic [DataWidth-1:0] r_data_o,
    output logic [1:0]           r_resp_o,
    output logic                 r_last_o,
    // debug / CSR
    input  logic                 clr_i,
    output logic [CntWidth-1:0]  miss_cnt_o,
    output logic [AddrWidth-1:0] miss_addr_o
);

    typedef enum logic [1:0] {W_IDLE, W_DRAIN, W_RESP} err_wr_state_e;
    typedef enum logic       {R_IDLE, R_DATA}          err_rd_state_e;

    err_wr_state_e        wr_state_q, wr_state_d;
    err_rd_state_e        rd_state_q, rd_state_d;
    logic [IdWidth-1:0]   aw_id_q, aw_id_d;
    logic [IdWidth-1:0]   ar_id_q, ar_id_d;
    logic [7:0]           ar_len_q, ar_len_d;
    logic [7:0]           beat_q, beat_d;
    logic [CntWidth-1:0]  miss_cnt_q, miss_cnt_d;
    logic [AddrWidth-1:0] miss_addr_q, miss_addr_d;
    // Holds the address channels closed while reset is asserted; readies
    // open the first cycle after reset is released.
    logic                 rdy_q;

    logic aw_hs, ar_hs;

    // The W stream is terminated by w_last_i alone; the AW length is only
    // informational and deliberately not compared against the beat count.
    logic unused_aw_len;
    assign unused_aw_len = ^aw_len_i;

    assign aw_hs = aw_valid_i & aw_ready_o;
    assign ar_hs = ar_valid_i & ar_ready_o;

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_state_q  <= W_IDLE;
            rd_state_q  <= R_IDLE;
            aw_id_q     <= '0;
            ar_id_q     <= '0;
            ar_len_q    <= '0;
            beat_q      <= '0;
            miss_cnt_q  <= '0;
            miss_addr_q <= '0;
            rdy_q       <= 1'b0;
        end else begin
            wr_state_q  <= wr_state_d;
            rd_state_q  <= rd_state_d;
            aw_id_q     <= aw_id_d;
            ar_id_q     <= ar_id_d;
            ar_len_q    <= ar_len_d;
            beat_q      <= beat_d;
            miss_cnt_q  <= miss_cnt_d;
            miss_addr_q <= miss_addr_d;
            rdy_q       <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Write FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        wr_state_d = wr_state_q;
        aw_id_d    = aw_id_q;
        unique case (wr_state_q)
            W_IDLE: begin
                if (aw_hs) begin
                    aw_id_d    = aw_id_i;
                    wr_state_d = W_DRAIN;
                end
            end
            W_DRAIN: begin
                // w_ready_o is high throughout this state
                if (w_valid_i && w_last_i) begin
                    wr_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (b_ready_i) begin
                    wr_state_d = W_IDLE;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    // Write FSM: outputs
    always_comb begin
        aw_ready_o = 1'b0;
        w_ready_o  = 1'b0;
        b_valid_o  = 1'b0;
        unique case (wr_state_q)
            W_IDLE:  aw_ready_o = rdy_q;
            W_DRAIN: w_ready_o  = 1'b1;
            W_RESP:  b_valid_o  = 1'b1;
            default: ;
        endcase
    end

    assign b_id_o   = aw_id_q;
    assign b_resp_o = AXI_RESP_DECERR;

    // ------------------------------------------------------------------
    // Read FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        rd_state_d = rd_state_q;
        ar_id_d    = ar_id_q;
        ar_len_d   = ar_len_q;
        beat_d     = beat_q;
        unique case (rd_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    ar_id_d    = ar_id_i;
                    ar_len_d   = ar_len_i;
                    beat_d     = '0;
                    rd_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (r_ready_i) begin
                    // Leaving on the last beat means beat_q never has to
                    // step past ar_len_q, so len=255 cannot wrap early.
                    if (r_last_o) begin
                        rd_state_d = R_IDLE;
                    end else begin
                        beat_d = beat_q + 8'd1;
                    end
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    // Read FSM: outputs
    always_comb begin
        ar_ready_o = 1'b0;
        r_valid_o  = 1'b0;
        r_last_o   = 1'b0;
        unique case (rd_state_q)
            R_IDLE: ar_ready_o = rdy_q;
            R_DATA: begin
                r_valid_o = 1'b1;
                r_last_o  = (beat_q == ar_len_q);
            end
            default: ;
        endcase
    end

    assign r_id_o   = ar_id_q;
    assign r_data_o = RespData;
    assign r_resp_o = AXI_RESP_DECERR;

    // ------------------------------------------------------------------
    // Saturating miss counter and last offending address
    // ------------------------------------------------------------------
    logic [1:0]        hs_cnt;
    logic [CntWidth:0] cnt_sum;

    assign hs_cnt  = {1'b0, aw_hs} + {1'b0, ar_hs};
    // One extra bit catches overflow, including +2 from max-1.
    assign cnt_sum = {1'b0, miss_cnt_q} + {{(CntWidth - 1){1'b0}}, hs_cnt};

    always_comb begin
        miss_cnt_d = miss_cnt_q;
        if (clr_i) begin
            miss_cnt_d = '0;
        end else if (cnt_sum[CntWidth]) begin
            miss_cnt_d = '1;
        end else begin
            miss_cnt_d = cnt_sum[CntWidth-1:0];
        end
    end

    // AR takes precedence when both channels hand off in the same cycle.
    always_comb begin
        miss_addr_d = miss_addr_q;
        if (ar_hs) begin
            miss_addr_d = ar_addr_i;
        end else if (aw_hs) begin
            miss_addr_d = aw_addr_i;
        end
    end

    assign miss_cnt_o  = miss_cnt_q;
    assign miss_addr_o = miss_addr_q;

endmodule

// File: tb/tb_soc_decerr_slv.sv
module tb_soc_decerr_slv;

    localparam logic [63:0] EXP_DATA = 64'hBADC_AB1E_BADC_AB1E;
    localparam longint unsigned MAX_CNT   = 64'hFFFF_FFFF;
    localparam longint unsigned MAX_CNT_S = 64'd7;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        aw_valid, aw_ready;
    logic [4:0]  aw_id;
    logic [63:0] aw_addr;
    logic [7:0]  aw_len;
    logic        w_valid, w_ready, w_last;
    logic        b_valid, b_ready;
    logic [4:0]  b_id;
    logic [1:0]  b_resp;
    logic        ar_valid, ar_ready;
    logic [4:0]  ar_id;
    logic [63:0] ar_addr;
    logic [7:0]  ar_len;
    logic        r_valid, r_ready;
    logic [4:0]  r_id;
    logic [63:0] r_data;
    logic [1:0]  r_resp;
    logic        r_last;
    logic        clr;
    logic [31:0] miss_cnt;
    logic [63:0] miss_addr;
    logic [2:0]  miss_cnt_s;

    logic        unused_s_aw_ready, unused_s_w_ready, unused_s_b_valid;
    logic [4:0]  unused_s_b_id, unused_s_r_id;
    logic [1:0]  unused_s_b_resp, unused_s_r_resp;
    logic        unused_s_ar_ready, unused_s_r_valid, unused_s_r_last;
    logic [63:0] unused_s_r_data, unused_s_miss_addr;

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    longint unsigned exp_cnt   = 0;
    longint unsigned exp_cnt_s = 0;
    logic [63:0]     exp_addr  = '0;

    always #5 clk = ~clk;

    soc_decerr_slv dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .aw_valid_i(aw_valid), .aw_ready_o(aw_ready), .aw_id_i(aw_id),
        .aw_addr_i(aw_addr), .aw_len_i(aw_len),
        .w_valid_i(w_valid), .w_ready_o(w_ready), .w_last_i(w_last),
        .b_valid_o(b_valid), .b_ready_i(b_ready), .b_id_o(b_id), .b_resp_o(b_resp),
        .ar_valid_i(ar_valid), .ar_ready_o(ar_ready), .ar_id_i(ar_id),
        .ar_addr_i(ar_addr), .ar_len_i(ar_len),
        .r_valid_o(r_valid), .r_ready_i(r_ready), .r_id_o(r_id), .r_data_o(r_data),
        .r_resp_o(r_resp), .r_last_o(r_last),
        .clr_i(clr), .miss_cnt_o(miss_cnt), .miss_addr_o(miss_addr)
    );

    // Narrow-counter instance sharing the same stimulus, so saturation
    // (including +2 from max-1) is reachable in a few transactions.
    soc_decerr_slv #(.CntWidth(3)) dut_s (
        .clk_i(clk), .rst_ni(rst_ni),
        .aw_valid_i(aw_valid), .aw_ready_o(unused_s_aw_ready), .aw_id_i(aw_id),
        .aw_addr_i(aw_addr), .aw_len_i(aw_len),
        .w_valid_i(w_valid), .w_ready_o(unused_s_w_ready), .w_last_i(w_last),
        .b_valid_o(unused_s_b_valid), .b_ready_i(b_ready), .b_id_o(unused_s_b_id),
        .b_resp_o(unused_s_b_resp),
        .ar_valid_i(ar_valid), .ar_ready_o(unused_s_ar_ready), .ar_id_i(ar_id),
        .ar_addr_i(ar_addr), .ar_len_i(ar_len),
        .r_valid_o(unused_s_r_valid), .r_ready_i(r_ready), .r_id_o(unused_s_r_id),
        .r_data_o(unused_s_r_data), .r_resp_o(unused_s_r_resp), .r_last_o(unused_s_r_last),
        .clr_i(clr), .miss_cnt_o(miss_cnt_s), .miss_addr_o(unused_s_miss_addr)
    );

    // Reference: n accepted requests this cycle, clear has priority,
    // address updated when upd is set.
    function automatic void model_step(int n, bit do_clr, bit upd, logic [63:0] a);
        if (do_clr) begin
            exp_cnt   = 0;
            exp_cnt_s = 0;
        end else begin
            exp_cnt   = (exp_cnt + n > MAX_CNT) ? MAX_CNT : exp_cnt + n;
            exp_cnt_s = (exp_cnt_s + n > MAX_CNT_S) ? MAX_CNT_S : exp_cnt_s + n;
        end
        if (upd) exp_addr = a;
    endfunction

    function automatic void model_reset();
        exp_cnt   = 0;
        exp_cnt_s = 0;
        exp_addr  = '0;
    endfunction

    // All tasks begin and end just after a negedge, with valids low.
    task automatic test_reset();
        rst_ni = 1'b0; aw_valid = 0; aw_id = 0; aw_addr = 0; aw_len = 0;
        w_valid = 0; w_last = 0; b_ready = 0; ar_valid = 0; ar_id = 0;
        ar_addr = 0; ar_len = 0; r_ready = 0; clr = 0;
        repeat (3) @(negedge clk);
        model_reset();
        n_cmp++; if ({aw_ready, ar_ready, w_ready, b_valid, r_valid, r_last} !== 6'b0) begin
            n_err++; $display("FAIL reset_ctrl: got %b want 000000",
                              {aw_ready, ar_ready, w_ready, b_valid, r_valid, r_last});
        end
        n_cmp++; if (miss_cnt !== 32'd0 || miss_addr !== 64'd0) begin
            n_err++; $display("FAIL reset_miss: got cnt=%h addr=%h want 0/0", miss_cnt, miss_addr);
        end
        rst_ni = 1'b1;
        @(negedge clk);
        n_cmp++; if (aw_ready !== 1'b1 || ar_ready !== 1'b1 || w_ready !== 1'b0) begin
            n_err++; $display("FAIL reset_release: got aw=%b ar=%b w=%b want 1 1 0",
                              aw_ready, ar_ready, w_ready);
        end
        $display("RESET released, readies aw=%b ar=%b", aw_ready, ar_ready);
    endtask

    task automatic write_txn(input logic [4:0] id, input logic [63:0] addr,
                             input int nbeats, input bit stall);
        int bwait;
        n_cmp++; if (aw_ready !== 1'b1 || w_ready !== 1'b0) begin
            n_err++; $display("FAIL wr_idle: got aw_ready=%b w_ready=%b want 1 0", aw_ready, w_ready);
        end
        aw_valid = 1; aw_id = id; aw_addr = addr; aw_len = 8'(nbeats - 1);
        @(negedge clk);
        model_step(1, 0, 1, addr);
        aw_valid = 0;
        n_cmp++; if (aw_ready !== 1'b0 || miss_cnt !== 32'(exp_cnt) || miss_cnt_s !== 3'(exp_cnt_s)
                     || miss_addr !== exp_addr) begin
            n_err++; $display("FAIL wr_accept: got ardy=%b cnt=%h cnt_s=%h addr=%h want 0 %h %h %h",
                              aw_ready, miss_cnt, miss_cnt_s, miss_addr,
                              32'(exp_cnt), 3'(exp_cnt_s), exp_addr);
        end
        for (int i = 0; i < nbeats; i++) begin
            if (stall && ($urandom % 2 == 1)) begin
                w_valid = 0;
                @(negedge clk);
            end
            n_cmp++; if (w_ready !== 1'b1 || b_valid !== 1'b0) begin
                n_err++; $display("FAIL wr_drain beat %0d: got w_ready=%b b_valid=%b want 1 0",
                                  i, w_ready, b_valid);
            end
            w_valid = 1; w_last = (i == nbeats - 1);
            @(negedge clk);
        end
        w_valid = 0; w_last = 0;
        n_cmp++; if (b_valid !== 1'b1 || b_id !== id || b_resp !== 2'b11 || w_ready !== 1'b0) begin
            n_err++; $display("FAIL wr_bresp: got bv=%b id=%h resp=%b wr=%b want 1 %h 11 0",
                              b_valid, b_id, b_resp, w_ready, id);
        end
        bwait = stall ? int'($urandom_range(0, 3)) : 0;
        for (int i = 0; i < bwait; i++) begin
            @(negedge clk);
            n_cmp++; if (b_valid !== 1'b1 || b_id !== id) begin
                n_err++; $display("FAIL wr_bhold: got bv=%b id=%h want 1 %h", b_valid, b_id, id);
            end
        end
        b_ready = 1;
        @(negedge clk);
        b_ready = 0;
        n_cmp++; if (b_valid !== 1'b0 || aw_ready !== 1'b1) begin
            n_err++; $display("FAIL wr_done: got bv=%b aw_ready=%b want 0 1", b_valid, aw_ready);
        end
        $display("WR id=%h addr=%h beats=%0d cnt=%h", id, addr, nbeats, miss_cnt);
    endtask

    // mode 0: r_ready high, 1: toggled 1/0, 2: random (at least 1 in 3)
    task automatic read_txn(input logic [4:0] id, input logic [63:0] addr,
                            input int len, input int mode, input bit do_clr);
        int  beat = 0;
        int  cyc = 0;
        bit  rdy;
        n_cmp++; if (ar_ready !== 1'b1) begin
            n_err++; $display("FAIL rd_idle: got ar_ready=%b want 1", ar_ready);
        end
        ar_valid = 1; ar_id = id; ar_addr = addr; ar_len = 8'(len); clr = do_clr;
        @(negedge clk);
        model_step(1, do_clr, 1, addr);
        ar_valid = 0; clr = 0;
        n_cmp++; if (ar_ready !== 1'b0 || miss_cnt !== 32'(exp_cnt) || miss_cnt_s !== 3'(exp_cnt_s)
                     || miss_addr !== exp_addr) begin
            n_err++; $display("FAIL rd_accept: got ardy=%b cnt=%h cnt_s=%h addr=%h want 0 %h %h %h",
                              ar_ready, miss_cnt, miss_cnt_s, miss_addr,
                              32'(exp_cnt), 3'(exp_cnt_s), exp_addr);
        end
        while (beat <= len && cyc < 3 * (len + 1) + 8) begin
            n_cmp++; if (r_valid !== 1'b1 || r_id !== id || r_data !== EXP_DATA || r_resp !== 2'b11
                         || r_last !== (beat == len)) begin
                n_err++; $display("FAIL rd_beat %0d: got v=%b id=%h d=%h resp=%b last=%b want 1 %h %h 11 %b",
                                  beat, r_valid, r_id, r_data, r_resp, r_last, id, EXP_DATA, beat == len);
                if (r_valid !== 1'b1) break;
            end
            case (mode)
                0:       rdy = 1;
                1:       rdy = (cyc % 2 == 0);
                default: rdy = ($urandom % 2 == 1) || (cyc % 3 == 2);
            endcase
            r_ready = rdy;
            @(negedge clk);
            if (rdy) beat++;
            cyc++;
        end
        r_ready = 0;
        n_cmp++; if (beat != len + 1 || r_valid !== 1'b0 || ar_ready !== 1'b1) begin
            n_err++; $display("FAIL rd_done: got beats=%0d rv=%b ar_ready=%b want %0d 0 1",
                              beat, r_valid, ar_ready, len + 1);
        end
        $display("RD id=%h addr=%h len=%0d mode=%0d beats=%0d cycles=%0d cnt=%h",
                 id, addr, len, mode, beat, cyc, miss_cnt);
    endtask

    task automatic test_dual(input logic [4:0] wid, input logic [63:0] waddr,
                             input logic [4:0] rid, input logic [63:0] raddr);
        n_cmp++; if (aw_ready !== 1'b1 || ar_ready !== 1'b1) begin
            n_err++; $display("FAIL dual_idle: got aw=%b ar=%b want 1 1", aw_ready, ar_ready);
        end
        aw_valid = 1; aw_id = wid; aw_addr = waddr; aw_len = 0;
        ar_valid = 1; ar_id = rid; ar_addr = raddr; ar_len = 0;
        @(negedge clk);
        model_step(2, 0, 1, raddr);
        aw_valid = 0; ar_valid = 0;
        n_cmp++; if (miss_cnt !== 32'(exp_cnt) || miss_cnt_s !== 3'(exp_cnt_s) || miss_addr !== exp_addr) begin
            n_err++; $display("FAIL dual_count: got cnt=%h cnt_s=%h addr=%h want %h %h %h",
                              miss_cnt, miss_cnt_s, miss_addr, 32'(exp_cnt), 3'(exp_cnt_s), exp_addr);
        end
        n_cmp++; if (r_valid !== 1'b1 || r_last !== 1'b1 || r_id !== rid || w_ready !== 1'b1) begin
            n_err++; $display("FAIL dual_busy: got rv=%b rl=%b rid=%h wr=%b want 1 1 %h 1",
                              r_valid, r_last, r_id, w_ready, rid);
        end
        w_valid = 1; w_last = 1; r_ready = 1;
        @(negedge clk);
        w_valid = 0; w_last = 0; r_ready = 0;
        n_cmp++; if (r_valid !== 1'b0 || ar_ready !== 1'b1 || b_valid !== 1'b1 || b_id !== wid) begin
            n_err++; $display("FAIL dual_resp: got rv=%b ar=%b bv=%b bid=%h want 0 1 1 %h",
                              r_valid, ar_ready, b_valid, b_id, wid);
        end
        b_ready = 1;
        @(negedge clk);
        b_ready = 0;
        n_cmp++; if (b_valid !== 1'b0 || aw_ready !== 1'b1) begin
            n_err++; $display("FAIL dual_done: got bv=%b aw=%b want 0 1", b_valid, aw_ready);
        end
        $display("DUAL wid=%h waddr=%h rid=%h raddr=%h cnt=%h cnt_s=%h",
                 wid, waddr, rid, raddr, miss_cnt, miss_cnt_s);
    endtask

    task automatic test_w_before_aw();
        w_valid = 1; w_last = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++; if (w_ready !== 1'b0 || b_valid !== 1'b0) begin
                n_err++; $display("FAIL w_early %0d: got w_ready=%b bv=%b want 0 0", i, w_ready, b_valid);
            end
        end
        aw_valid = 1; aw_id = 5'h07; aw_addr = 64'h0000_0000_DEAD_0000; aw_len = 0;
        @(negedge clk);
        model_step(1, 0, 1, 64'h0000_0000_DEAD_0000);
        aw_valid = 0;
        n_cmp++; if (w_ready !== 1'b1 || b_valid !== 1'b0) begin
            n_err++; $display("FAIL w_after_aw: got w_ready=%b bv=%b want 1 0", w_ready, b_valid);
        end
        @(negedge clk);
        w_valid = 0; w_last = 0;
        n_cmp++; if (b_valid !== 1'b1 || b_id !== 5'h07 || miss_cnt !== 32'(exp_cnt)) begin
            n_err++; $display("FAIL w_early_b: got bv=%b id=%h cnt=%h want 1 07 %h",
                              b_valid, b_id, miss_cnt, 32'(exp_cnt));
        end
        b_ready = 1;
        @(negedge clk);
        b_ready = 0;
        $display("WR early-W id=07 cnt=%h", miss_cnt);
    endtask

    task automatic test_saturation();
        // clear concurrent with an AR: counter 0, address still updated
        read_txn(5'h01, 64'h0000_0000_0000_0C00, 0, 0, 1);
        for (int i = 0; i < 4; i++)
            test_dual(5'(i), 64'h100 + 64'(i), 5'(i + 8), 64'h200 + 64'(i));
        n_cmp++; if (miss_cnt_s !== 3'd7 || miss_cnt !== 32'd8) begin
            n_err++; $display("FAIL saturate: got cnt_s=%h cnt=%h want 7 8", miss_cnt_s, miss_cnt);
        end
        $display("SAT cnt_s=%h cnt=%h", miss_cnt_s, miss_cnt);
    endtask

    task automatic test_random(input int n);
        for (int t = 0; t < n; t++) begin
            if ($urandom % 2 == 0)
                write_txn(5'($urandom), {$urandom, $urandom}, int'($urandom_range(1, 8)), 1);
            else
                read_txn(5'($urandom), {$urandom, $urandom}, int'($urandom_range(0, 15)),
                         int'($urandom_range(0, 2)), 0);
        end
    endtask

    task automatic test_reset_mid_read();
        n_cmp++; if (ar_ready !== 1'b1) begin
            n_err++; $display("FAIL rst_rd_idle: got ar_ready=%b want 1", ar_ready);
        end
        ar_valid = 1; ar_id = 5'h0A; ar_addr = 64'h1234; ar_len = 7;
        @(negedge clk);
        model_step(1, 0, 1, 64'h1234);
        ar_valid = 0; r_ready = 1;
        repeat (3) @(negedge clk);
        n_cmp++; if (r_valid !== 1'b1 || r_last !== 1'b0) begin
            n_err++; $display("FAIL rst_rd_beat3: got rv=%b rl=%b want 1 0", r_valid, r_last);
        end
        r_ready = 0; rst_ni = 0;
        @(negedge clk);
        model_reset();
        n_cmp++; if (r_valid !== 1'b0 || ar_ready !== 1'b0 || miss_cnt !== 32'(exp_cnt)) begin
            n_err++; $display("FAIL rst_rd_drop: got rv=%b ar=%b cnt=%h want 0 0 0", r_valid, ar_ready, miss_cnt);
        end
        rst_ni = 1;
        @(negedge clk);
        n_cmp++; if (ar_ready !== 1'b1 || aw_ready !== 1'b1 || r_valid !== 1'b0 || miss_addr !== exp_addr) begin
            n_err++; $display("FAIL rst_rd_release: got ar=%b aw=%b rv=%b addr=%h want 1 1 0 0",
                              ar_ready, aw_ready, r_valid, miss_addr);
        end
        $display("RST mid-read, ar_ready=%b cnt=%h", ar_ready, miss_cnt);
    endtask

    initial begin
        test_reset();
        write_txn(5'h13, 64'h0000_0000_5000_0000, 4, 0);
        read_txn(5'h02, 64'h0000_0000_6000_0000, 7, 1, 0);
        test_dual(5'h04, 64'hA, 5'h05, 64'hB);
        test_w_before_aw();
        read_txn(5'h1F, 64'h0000_0000_7000_0040, 0, 0, 0);
        test_saturation();
        test_random(30);
        read_txn(5'h11, 64'hFFFF_0000_0000_1000, 255, 0, 0);
        test_reset_mid_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
